// File: rtl/lane_vinsn_queue.sv
// Per-lane vector instruction queue: captures lane-bound requests from the sequencer broadcast,
// issues the head to ALU/MFPU once hazards drain, and returns completions as vinsn_done pulses.

package ara_pkg;

  localparam int unsigned NrVInsn = 8;

  typedef logic [$clog2(NrVInsn)-1:0] vid_t;

  typedef enum logic [2:0] {
    VFU_None,
    VFU_Alu,
    VFU_MFpu,
    VFU_LoadUnit,
    VFU_StoreUnit,
    VFU_SlideUnit,
    VFU_MaskUnit
  } vfu_e;

  typedef struct packed {
    vid_t               id;
    vfu_e               vfu;
    logic [7:0]         op;
    logic [15:0]        vl;
    logic [NrVInsn-1:0] hazard_vs1;
    logic [NrVInsn-1:0] hazard_vs2;
    logic [NrVInsn-1:0] hazard_vd;
    logic [NrVInsn-1:0] hazard_vm;
  } pe_req_t;

  typedef struct packed {
    logic [NrVInsn-1:0] vinsn_done;
  } pe_resp_t;

endpackage

module lane_vinsn_queue
  import ara_pkg::*;
#(
  parameter int unsigned NrLanes         = 1,
  parameter int unsigned VInsnQueueDepth = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  pe_req_t            pe_req_i,
  input  logic               pe_req_valid_i,
  output logic               pe_req_ready_o,
  input  logic [NrVInsn-1:0] vinsn_running_i,
  output pe_req_t            alu_req_o,
  output logic               alu_req_valid_o,
  input  logic               alu_req_ready_i,
  output pe_req_t            mfpu_req_o,
  output logic               mfpu_req_valid_o,
  input  logic               mfpu_req_ready_i,
  input  logic [NrVInsn-1:0] alu_vinsn_done_i,
  input  logic [NrVInsn-1:0] mfpu_vinsn_done_i,
  output pe_resp_t           pe_resp_o,
  output logic               lane_idle_o
);

  localparam int unsigned PtrW = $clog2(VInsnQueueDepth);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(VInsnQueueDepth);

  if (NrLanes < 1 || VInsnQueueDepth < 2 ||
      (VInsnQueueDepth & (VInsnQueueDepth - 1)) != 0) begin : g_param_check
    $error("lane_vinsn_queue: invalid NrLanes or VInsnQueueDepth");
  end

  pe_req_t            r_queue [VInsnQueueDepth];
  pe_req_t            w_queue_d [VInsnQueueDepth];
  logic [PtrW-1:0]    r_rd_ptr, r_wr_ptr, w_rd_ptr_d, w_wr_ptr_d;
  logic [PtrW:0]      r_count, w_count_d;
  vid_t               r_last_id, w_last_id_d;
  logic               r_last_valid, w_last_valid_d;
  logic [NrVInsn-1:0] r_issued, w_issued_d;
  logic [NrVInsn-1:0] r_done, w_done_d;

  pe_req_t w_new, w_head;
  logic    w_dup, w_accept, w_enq, w_issue, w_deq;

  // Hazard masks are filtered against the running set both on capture and every cycle.
  always_comb begin
    w_new            = pe_req_i;
    w_new.hazard_vs1 = pe_req_i.hazard_vs1 & vinsn_running_i;
    w_new.hazard_vs2 = pe_req_i.hazard_vs2 & vinsn_running_i;
    w_new.hazard_vd  = pe_req_i.hazard_vd & vinsn_running_i;
    w_new.hazard_vm  = pe_req_i.hazard_vm & vinsn_running_i;

    w_head            = r_queue[r_rd_ptr];
    w_head.hazard_vs1 = w_head.hazard_vs1 & vinsn_running_i;
    w_head.hazard_vs2 = w_head.hazard_vs2 & vinsn_running_i;
    w_head.hazard_vd  = w_head.hazard_vd & vinsn_running_i;
    w_head.hazard_vm  = w_head.hazard_vm & vinsn_running_i;
  end

  assign pe_req_ready_o = (r_count != FullCnt);
  assign w_dup    = pe_req_valid_i && r_last_valid && (pe_req_i.id == r_last_id);
  assign w_accept = pe_req_valid_i && pe_req_ready_o && !w_dup;
  assign w_enq    = w_accept && (pe_req_i.vfu == VFU_Alu || pe_req_i.vfu == VFU_MFpu);

  assign w_issue = (r_count != '0) &&
                   ((w_head.hazard_vs1 | w_head.hazard_vs2 |
                     w_head.hazard_vd | w_head.hazard_vm) == '0);

  assign alu_req_o        = w_head;
  assign mfpu_req_o       = w_head;
  assign alu_req_valid_o  = w_issue && (w_head.vfu == VFU_Alu);
  assign mfpu_req_valid_o = w_issue && (w_head.vfu == VFU_MFpu);
  assign w_deq = (alu_req_valid_o && alu_req_ready_i) || (mfpu_req_valid_o && mfpu_req_ready_i);

  always_comb begin
    w_queue_d = r_queue;
    for (int i = 0; i < int'(VInsnQueueDepth); i++) begin
      w_queue_d[i].hazard_vs1 = r_queue[i].hazard_vs1 & vinsn_running_i;
      w_queue_d[i].hazard_vs2 = r_queue[i].hazard_vs2 & vinsn_running_i;
      w_queue_d[i].hazard_vd  = r_queue[i].hazard_vd & vinsn_running_i;
      w_queue_d[i].hazard_vm  = r_queue[i].hazard_vm & vinsn_running_i;
    end
    if (w_enq) w_queue_d[r_wr_ptr] = w_new;

    w_wr_ptr_d = w_enq ? r_wr_ptr + PtrW'(1) : r_wr_ptr;
    w_rd_ptr_d = w_deq ? r_rd_ptr + PtrW'(1) : r_rd_ptr;
    w_count_d  = r_count;
    if (w_enq && !w_deq) w_count_d = r_count + (PtrW + 1)'(1);
    if (!w_enq && w_deq) w_count_d = r_count - (PtrW + 1)'(1);

    w_last_id_d    = r_last_id;
    w_last_valid_d = r_last_valid;
    if (w_accept) begin
      w_last_id_d    = pe_req_i.id;
      w_last_valid_d = 1'b1;
    end else if (!pe_req_valid_i || pe_req_i.id != r_last_id) begin
      w_last_valid_d = 1'b0;
    end

    // A fresh issue of an id overrides a completion of its previous instance.
    w_done_d   = (alu_vinsn_done_i | mfpu_vinsn_done_i) & r_issued;
    w_issued_d = r_issued & ~w_done_d;
    if (w_deq) w_issued_d[w_head.id] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(VInsnQueueDepth); i++) r_queue[i] <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_last_id    <= '0;
      r_last_valid <= 1'b0;
      r_issued     <= '0;
      r_done       <= '0;
    end else begin
      r_queue      <= w_queue_d;
      r_rd_ptr     <= w_rd_ptr_d;
      r_wr_ptr     <= w_wr_ptr_d;
      r_count      <= w_count_d;
      r_last_id    <= w_last_id_d;
      r_last_valid <= w_last_valid_d;
      r_issued     <= w_issued_d;
      r_done       <= w_done_d;
    end
  end

  assign pe_resp_o.vinsn_done = r_done;
  assign lane_idle_o = (r_count == '0) && (r_issued == '0);

endmodule

// File: tb/tb_lane_vinsn_queue.sv
// Directed bench for lane_vinsn_queue: duplicate filter, hazard stall, full/wrap, routing,
// reset and completion return.

module tb_lane_vinsn_queue;
  import ara_pkg::*;

  logic               clk = 1'b0;
  logic               rst_ni = 1'b1;
  pe_req_t            pe_req;
  logic               pe_req_valid;
  logic               pe_req_ready;
  logic [NrVInsn-1:0] running;
  pe_req_t            alu_req, mfpu_req;
  logic               alu_valid, alu_ready, mfpu_valid, mfpu_ready;
  logic [NrVInsn-1:0] alu_done, mfpu_done;
  pe_resp_t           pe_resp;
  logic               lane_idle;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lane_vinsn_queue #(
    .NrLanes        (1),
    .VInsnQueueDepth(4)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .pe_req_i         (pe_req),
    .pe_req_valid_i   (pe_req_valid),
    .pe_req_ready_o   (pe_req_ready),
    .vinsn_running_i  (running),
    .alu_req_o        (alu_req),
    .alu_req_valid_o  (alu_valid),
    .alu_req_ready_i  (alu_ready),
    .mfpu_req_o       (mfpu_req),
    .mfpu_req_valid_o (mfpu_valid),
    .mfpu_req_ready_i (mfpu_ready),
    .alu_vinsn_done_i (alu_done),
    .mfpu_vinsn_done_i(mfpu_done),
    .pe_resp_o        (pe_resp),
    .lane_idle_o      (lane_idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input vfu_e vfu, input logic [NrVInsn-1:0] haz);
    pe_req            = '0;
    pe_req.id         = vid_t'(id);
    pe_req.vfu        = vfu;
    pe_req.op         = 8'(id + 16);
    pe_req.hazard_vs1 = haz;
    pe_req_valid      = 1'b1;
  endtask

  initial begin
    pe_req       = '0;
    pe_req_valid = 1'b0;
    running      = '0;
    alu_ready    = 1'b0;
    mfpu_ready   = 1'b0;
    alu_done     = '0;
    mfpu_done    = '0;
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_ready", 32'(pe_req_ready), 1);
    chk("rst_idle", 32'(lane_idle), 1);
    chk("rst_alu_valid", 32'(alu_valid), 0);
    chk("rst_mfpu_valid", 32'(mfpu_valid), 0);
    chk("rst_resp", 32'(pe_resp.vinsn_done), 0);
    step();
    rst_ni = 1'b1;
    step();

    // Duplicate filter: id 2 held four cycles must enqueue once
    send(2, VFU_Alu, '0);
    repeat (4) step();
    chk("dup_head_id", 32'(alu_req.id), 2);
    chk("dup_head_valid", 32'(alu_valid), 1);
    send(3, VFU_Alu, '0);
    step();
    pe_req_valid = 1'b0;
    chk("dup_hold_head", 32'(alu_req.id), 2);
    alu_ready = 1'b1;
    step();
    chk("dup_second_id", 32'(alu_req.id), 3);
    chk("dup_second_valid", 32'(alu_valid), 1);
    step();
    alu_ready = 1'b0;
    chk("dup_drained", 32'(alu_valid), 0);
    chk("dup_busy", 32'(lane_idle), 0);
    alu_done  = 8'h04;
    mfpu_done = 8'h08;
    step();
    alu_done  = '0;
    mfpu_done = '0;
    chk("dup_done_resp", 32'(pe_resp.vinsn_done), 32'h0c);
    chk("dup_done_idle", 32'(lane_idle), 1);
    step();
    chk("dup_resp_pulse", 32'(pe_resp.vinsn_done), 0);

    // Hazard stall on running id 0
    running   = 8'h01;
    alu_ready = 1'b1;
    send(1, VFU_Alu, 8'h01);
    step();
    pe_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("haz_stall", 32'(alu_valid), 0);
      step();
    end
    running = '0;
    #1;
    chk("haz_release_valid", 32'(alu_valid), 1);
    chk("haz_release_field", 32'(alu_req.hazard_vs1), 0);
    step();
    alu_ready = 1'b0;
    chk("haz_dequeued", 32'(alu_valid), 0);
    alu_done = 8'h02;
    step();
    alu_done = '0;
    chk("haz_done_resp", 32'(pe_resp.vinsn_done), 32'h02);

    // Full and pointer wrap
    for (int i = 0; i < 4; i++) begin
      send(i, VFU_Alu, '0);
      step();
    end
    chk("full_ready_low", 32'(pe_req_ready), 0);
    send(4, VFU_Alu, '0);
    step();
    chk("full_wait_ready", 32'(pe_req_ready), 0);
    chk("full_head0", 32'(alu_req.id), 0);
    alu_ready = 1'b1;
    step();
    chk("full_ready_back", 32'(pe_req_ready), 1);
    chk("full_head1", 32'(alu_req.id), 1);
    step();
    pe_req_valid = 1'b0;
    chk("full_head2", 32'(alu_req.id), 2);
    chk("full_cnt3_ready", 32'(pe_req_ready), 1);
    step();
    chk("full_head3", 32'(alu_req.id), 3);
    step();
    chk("full_head4", 32'(alu_req.id), 4);
    chk("full_head4_valid", 32'(alu_valid), 1);
    step();
    alu_ready = 1'b0;
    chk("full_empty", 32'(alu_valid), 0);

    // Reset mid-run with three entries queued
    for (int i = 0; i < 3; i++) begin
      send(i, VFU_Alu, '0);
      step();
    end
    pe_req_valid = 1'b0;
    chk("mid_pre_valid", 32'(alu_valid), 1);
    chk("mid_pre_ready_busy", 32'(lane_idle), 0);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(pe_req_ready), 1);
    chk("mid_rst_alu_valid", 32'(alu_valid), 0);
    chk("mid_rst_mfpu_valid", 32'(mfpu_valid), 0);
    chk("mid_rst_resp", 32'(pe_resp.vinsn_done), 0);
    chk("mid_rst_idle", 32'(lane_idle), 1);
    step();
    rst_ni = 1'b1;
    step();

    // Routing by vfu
    send(5, VFU_MFpu, '0);
    step();
    send(6, VFU_Alu, '0);
    step();
    pe_req_valid = 1'b0;
    chk("route_mfpu_valid", 32'(mfpu_valid), 1);
    chk("route_alu_quiet", 32'(alu_valid), 0);
    chk("route_mfpu_id", 32'(mfpu_req.id), 5);
    mfpu_ready = 1'b1;
    step();
    mfpu_ready = 1'b0;
    chk("route_mfpu_quiet", 32'(mfpu_valid), 0);
    chk("route_alu_valid", 32'(alu_valid), 1);
    chk("route_alu_id", 32'(alu_req.id), 6);
    alu_ready = 1'b1;
    step();
    alu_ready = 1'b0;
    chk("route_alu_done", 32'(alu_valid), 0);
    send(7, VFU_LoadUnit, '0);
    step();
    pe_req_valid = 1'b0;
    step();
    chk("route_ld_alu", 32'(alu_valid), 0);
    chk("route_ld_mfpu", 32'(mfpu_valid), 0);
    chk("route_busy", 32'(lane_idle), 0);

    // Completion return
    alu_done = 8'h80;
    step();
    alu_done = '0;
    chk("cmp_stray", 32'(pe_resp.vinsn_done), 0);
    alu_done  = 8'h20;
    mfpu_done = 8'h40;
    step();
    alu_done  = '0;
    mfpu_done = '0;
    chk("cmp_resp", 32'(pe_resp.vinsn_done), 32'h60);
    chk("cmp_idle", 32'(lane_idle), 1);
    step();
    chk("cmp_pulse_end", 32'(pe_resp.vinsn_done), 0);
    chk("cmp_idle_hold", 32'(lane_idle), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
